arc_serial_alu: RTL

- Parametrised next-generation A&R arithmetic core: a bit-serial, digit-at-a-time register datapath with A, B and C registers of NDIG digits.
- Generalises the fixed 14-digit HP-style word to NDIG digits and adds a runtime BCD/hex radix mode.
- The word-select field comes from programmable digit bounds instead of an external WS strobe, and a valid/ready opcode handshake feeds it.
- It sits under the control/timing unit, which issues one opcode per word time and reads back the carry flag.

---
 rtl/arc_pkg.sv | 31 +++
 rtl/arc_dadj.sv | 42 ++++
 rtl/arc_serial_alu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/arc_pkg.sv
// Shared definitions for the A&R serial arithmetic core: opcode set, digit width and the
// digit-field membership test.
package arc_pkg;

   localparam int unsigned DIGW = 4;

   typedef enum logic [3:0] {
      OpNop    = 4'd0,
      OpAAddB  = 4'd1,
      OpASubB  = 4'd2,
      OpAAddC  = 4'd3,
      OpASubC  = 4'd4,
      OpCAddA  = 4'd5,
      OpCASubC = 4'd6,
      OpCInc   = 4'd7,
      OpCDec   = 4'd8,
      OpCNeg   = 4'd9,
      OpAClr   = 4'd10,
      OpCClr   = 4'd11,
      OpSwap   = 4'd12,
      OpSra    = 4'd13,
      OpSla    = 4'd14,
      OpCmp    = 4'd15
   } op_e;

   function automatic logic field_hit(input int unsigned digit, input int unsigned lo,
                                      input int unsigned hi);
      return (digit >= lo) && (digit <= hi);
   endfunction

endpackage

// File: rtl/arc_dadj.sv
// Serial digit adjuster: holds the first three result bits of a digit and, on the fourth,
// applies the BCD add/subtract correction and produces the digit carry/borrow.
module arc_dadj
   import arc_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            bit_i,
   input  logic            fa_co_i,
   input  logic            sub_i,
   input  logic            dec_i,
   output logic [DIGW-1:0] dig_o,
   output logic            co_o
);

   logic [DIGW-2:0] dly_q, dly_d;
   logic [DIGW-1:0] raw;
   logic            adj;

   always_comb begin
      dly_d = {bit_i, dly_q[DIGW-2:1]};
      raw   = {bit_i, dly_q};
      adj   = 1'b0;
      if (dec_i) begin
         adj = sub_i ? fa_co_i : (fa_co_i | (raw[3] & (raw[2] | raw[1])));
      end
      dig_o = raw;
      if (adj) begin
         dig_o = sub_i ? (raw - 4'd6) : (raw + 4'd6);
      end
      co_o = fa_co_i | adj;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dly_q <= '0;
      end else begin
         dly_q <= dly_d;
      end
   end

endmodule

// File: rtl/arc_serial_alu.sv
// Bit-serial A/B/C register arithmetic core: one opcode per word time, operating on a
// programmable digit field in BCD or hex, with a one-deep pending opcode slot.
module arc_serial_alu
   import arc_pkg::*;
#(
   parameter int unsigned NDIG = 14,
   parameter int unsigned PTRW = 4
) (
   input  logic                 cph2,
   input  logic                 rst,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [3:0]           op_code,
   input  logic [PTRW-1:0]      ws_lo,
   input  logic [PTRW-1:0]      ws_hi,
   input  logic                 dec_mode,
   output logic                 start,
   output logic                 carry,
   output logic [4*NDIG-1:0]    a_par,
   output logic [4*NDIG-1:0]    c_par
);

   localparam int unsigned W  = DIGW * NDIG;
   localparam int unsigned CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
   logic            carry_q, carry_d, cy_q, cy_d;
   logic [DIGW-1:0] prev_q, prev_d;
   logic            pend_v_q, pend_v_d, pend_dec_q, pend_dec_d, ex_dec_q, ex_dec_d;
   op_e             pend_op_q, pend_op_d, ex_op_q, ex_op_d;
   logic [PTRW-1:0] pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
   logic [PTRW-1:0] ex_lo_q, ex_lo_d, ex_hi_q, ex_hi_d;

   logic            last, accept, ex_ok, in_field, first_bit, bit3, hi_dig, lo_dig;
   logic [CW-3:0]   dig;
   logic [CW-1:0]   dbase;
   logic            x_bit, y_bit, sub, init, cin, s_bit, fa_co, adj_co;
   logic [DIGW-1:0] adj_dig;
   logic [W-1:0]    a_shr;

   assign last      = (cnt_q == LAST);
   assign op_ready  = !pend_v_q || last;
   assign accept    = op_valid && op_ready;
   assign dig       = cnt_q[CW-1:2];
   assign dbase     = {dig, 2'b00};
   assign bit3      = &cnt_q[1:0];
   assign ex_ok     = (ex_lo_q <= ex_hi_q) && (32'(ex_hi_q) < NDIG);
   assign in_field  = ex_ok && field_hit(32'(dig), 32'(ex_lo_q), 32'(ex_hi_q));
   assign first_bit = (32'(cnt_q) == DIGW * 32'(ex_lo_q));
   assign hi_dig    = (32'(dig) == 32'(ex_hi_q));
   assign lo_dig    = (32'(dig) == 32'(ex_lo_q));
   assign a_shr     = {{DIGW{1'b0}}, a_q[W-1:DIGW]};

   // Operand routing; OpCNeg uses borrow-in 0 so the result is the true complement 0-C.
   always_comb begin
      x_bit = a_q[cnt_q];
      y_bit = c_q[cnt_q];
      sub   = 1'b0;
      init  = 1'b0;
      unique case (ex_op_q)
         OpAAddB: y_bit = b_q[cnt_q];
         OpASubB: begin
            y_bit = b_q[cnt_q];
            sub   = 1'b1;
         end
         OpASubC, OpCASubC, OpCmp: sub = 1'b1;
         OpCInc: begin
            x_bit = c_q[cnt_q];
            y_bit = 1'b0;
            init  = 1'b1;
         end
         OpCDec: begin
            x_bit = c_q[cnt_q];
            y_bit = 1'b0;
            sub   = 1'b1;
            init  = 1'b1;
         end
         OpCNeg: begin
            x_bit = 1'b0;
            sub   = 1'b1;
         end
         default: ;
      endcase
      cin   = first_bit ? init : cy_q;
      s_bit = x_bit ^ y_bit ^ cin;
      fa_co = sub ? ((~x_bit & y_bit) | (~x_bit & cin) | (y_bit & cin))
                  : ((x_bit & y_bit) | (x_bit & cin) | (y_bit & cin));
   end

   arc_dadj u_dadj (
      .clk_i   (cph2),
      .rst_i   (rst),
      .bit_i   (s_bit),
      .fa_co_i (fa_co),
      .sub_i   (sub),
      .dec_i   (ex_dec_q),
      .dig_o   (adj_dig),
      .co_o    (adj_co)
   );

   always_comb begin
      cnt_d      = last ? '0 : cnt_q + CW'(1);
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      carry_d    = carry_q;
      cy_d       = cy_q;
      prev_d     = prev_q;
      pend_v_d   = pend_v_q;
      pend_op_d  = pend_op_q;
      pend_lo_d  = pend_lo_q;
      pend_hi_d  = pend_hi_q;
      pend_dec_d = pend_dec_q;
      ex_op_d    = ex_op_q;
      ex_lo_d    = ex_lo_q;
      ex_hi_d    = ex_hi_q;
      ex_dec_d   = ex_dec_q;

      // Original A digit, consumed by SLA one digit later.
      if (bit3) prev_d = a_q[dbase +: DIGW];

      if (in_field) begin
         cy_d = bit3 ? adj_co : fa_co;
         if (bit3) begin
            unique case (ex_op_q)
               OpAAddB, OpASubB, OpAAddC, OpASubC: a_d[dbase +: DIGW] = adj_dig;
               OpCAddA, OpCASubC, OpCInc, OpCDec, OpCNeg: c_d[dbase +: DIGW] = adj_dig;
               OpAClr: a_d[dbase +: DIGW] = '0;
               OpCClr: c_d[dbase +: DIGW] = '0;
               OpSwap: begin
                  a_d[dbase +: DIGW] = c_q[dbase +: DIGW];
                  c_d[dbase +: DIGW] = a_q[dbase +: DIGW];
               end
               OpSra: a_d[dbase +: DIGW] = hi_dig ? '0 : a_shr[dbase +: DIGW];
               OpSla: a_d[dbase +: DIGW] = lo_dig ? '0 : prev_q;
               default: ;
            endcase
            if (hi_dig && (ex_op_q != OpNop)) begin
               carry_d = ((ex_op_q >= OpAClr) && (ex_op_q <= OpSla)) ? 1'b0 : adj_co;
            end
         end
      end

      if (last && (ex_op_q != OpNop) && !ex_ok) carry_d = 1'b0;

      if (last) begin
         ex_op_d  = pend_v_q ? pend_op_q : OpNop;
         ex_lo_d  = pend_lo_q;
         ex_hi_d  = pend_hi_q;
         ex_dec_d = pend_dec_q;
         pend_v_d = 1'b0;
      end
      if (accept) begin
         pend_v_d   = 1'b1;
         pend_op_d  = op_e'(op_code);
         pend_lo_d  = ws_lo;
         pend_hi_d  = ws_hi;
         pend_dec_d = dec_mode;
      end
   end

   always_ff @(posedge cph2) begin
      if (rst) begin
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         carry_q    <= 1'b0;
         cy_q       <= 1'b0;
         prev_q     <= '0;
         pend_v_q   <= 1'b0;
         pend_op_q  <= OpNop;
         pend_lo_q  <= '0;
         pend_hi_q  <= '0;
         pend_dec_q <= 1'b0;
         ex_op_q    <= OpNop;
         ex_lo_q    <= '0;
         ex_hi_q    <= '0;
         ex_dec_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         carry_q    <= carry_d;
         cy_q       <= cy_d;
         prev_q     <= prev_d;
         pend_v_q   <= pend_v_d;
         pend_op_q  <= pend_op_d;
         pend_lo_q  <= pend_lo_d;
         pend_hi_q  <= pend_hi_d;
         pend_dec_q <= pend_dec_d;
         ex_op_q    <= ex_op_d;
         ex_lo_q    <= ex_lo_d;
         ex_hi_q    <= ex_hi_d;
         ex_dec_q   <= ex_dec_d;
      end
   end

   assign start = (cnt_q == '0);
   assign carry = carry_q;
   assign a_par = a_q;
   assign c_par = c_q;

endmodule
